uart_byte_tx: RTL and testbench

//   8-bit UART transmitter that serialises bytes LSB-first onto the txd line.

---
 rtl/uart_defs_pkg.sv | 28 ++
 rtl/uart_baud_cnt.sv | 40 ++++
 rtl/uart_byte_tx.sv | 133 +++++++++++++
 tb/tb_uart_byte_tx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encodings, parity-mode constants and the
// parity helper. Reused by the transmitter and the future receiver.
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Even mode yields the XOR of the byte; odd mode its complement.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    if (mode == PAR_ODD) begin
      p = ~^data;
    end else begin
      p = ^data;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each
// bit period with tick. clr restarts the period.
module uart_baud_cnt #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear, wrap at the end of a period, else increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_byte_tx.sv
// 8-bit UART transmitter, LSB first, optional even/odd parity. All outputs
// are registered and decoded from the next state, so txd tracks state exactly.
module uart_byte_tx
  import uart_defs::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  // Unsupported parity modes fall back to no parity bit.
  localparam bit HAS_PAR  = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

  uart_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;
  logic        clr;

  uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shreg_d  = tx_data;
          par_d    = parity_bit(tx_data, PARITY);
          bitcnt_d = 3'd0;
          state_d  = ST_START;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            bitcnt_d = 3'd0;
            state_d  = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  assign clr = (state_d != state_q);

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx (BAUD_DIV=16) with a per-cycle scoreboard of
// {txd, tx_busy, tx_done}; three instances cover parity none/even/odd.
module tb_uart_byte_tx;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  logic [7:0] data;
  logic [2:0] txd_v, busy_v, done_v;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  uart_byte_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(0)) u_p0 (
    .clk(clk), .rst(rst), .tx_start(start_v[0]), .tx_data(data),
    .tx_busy(busy_v[0]), .tx_done(done_v[0]), .txd(txd_v[0]));
  uart_byte_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(1)) u_p1 (
    .clk(clk), .rst(rst), .tx_start(start_v[1]), .tx_data(data),
    .tx_busy(busy_v[1]), .tx_done(done_v[1]), .txd(txd_v[1]));
  uart_byte_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(2)) u_p2 (
    .clk(clk), .rst(rst), .tx_start(start_v[2]), .tx_data(data),
    .tx_busy(busy_v[2]), .tx_done(done_v[2]), .txd(txd_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] obs(input int i);
    return {txd_v[i], busy_v[i], done_v[i]};
  endfunction

  task automatic chk(input string tag, input logic [2:0] o, input logic [2:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed={txd,busy,done}=%b expected=%b", tag, o, e);
    end
  endtask

  // Expected {txd,busy,done} for cycles 1.. after the accepting edge.
  function automatic void push_frame(input logic [7:0] d, input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    if (mode == 2) p = ~p;
    for (int c = 0; c < 16; c++) exp_q.push_back(3'b010);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < 16; c++) exp_q.push_back({d[b], 2'b10});
    if (mode != 0)
      for (int c = 0; c < 16; c++) exp_q.push_back({p, 2'b10});
    for (int c = 0; c < 16; c++) exp_q.push_back(3'b110);
    exp_q.push_back(3'b101);
  endfunction

  // Called at the negedge before the accepting edge; compares n cycles.
  task automatic drain(input int inst, input string tag, input int n,
                       input int release_at, input int chg_at,
                       input logic [7:0] chg_data, input bit noise);
    logic [2:0] e;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk($sformatf("%s.empty.c%0d", tag, k), obs(inst), 3'bxxx);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s.c%0d", tag, k), obs(inst), e);
      end
      if (k == release_at) start_v[inst] = 1'b0;
      if (k == chg_at) data = chg_data;
      if (noise && (k == 21 || k == 101)) start_v[inst] = 1'b0;
      if (noise && (k == 20 || k == 100)) begin
        start_v[inst] = 1'b1;
        data = data ^ 8'hFF;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_v = 3'b000;
    data = 8'h00;
    #12;
    for (int i = 0; i < 3; i++) chk($sformatf("reset.u%0d", i), obs(i), 3'b100);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Plain 8N1 frame
    data = 8'h32; start_v[0] = 1'b1; push_frame(8'h32, 0);
    drain(0, "t1", exp_q.size(), 1, 0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    // Even and odd parity on the same byte
    data = 8'h35; start_v[1] = 1'b1; push_frame(8'h35, 1);
    drain(1, "t2e", exp_q.size(), 1, 0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    data = 8'h35; start_v[2] = 1'b1; push_frame(8'h35, 2);
    drain(2, "t2o", exp_q.size(), 1, 0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    // tx_start held: back-to-back frames, data swapped in the tx_done cycle
    data = 8'h30; start_v[0] = 1'b1;
    push_frame(8'h30, 0); push_frame(8'h31, 0);
    drain(0, "t3", exp_q.size(), 200, 161, 8'h31, 1'b0);
    repeat (3) @(negedge clk);

    // Mid-frame start pulses and data changes are ignored
    data = 8'hA5; start_v[0] = 1'b1; push_frame(8'hA5, 0);
    drain(0, "t4", exp_q.size(), 1, 0, 8'h00, 1'b1);
    repeat (3) @(negedge clk);

    // Reset in the middle of the data bits
    data = 8'h5C; start_v[0] = 1'b1; push_frame(8'h5C, 0);
    drain(0, "t5pre", 69, 1, 0, 8'h00, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("t5.async", obs(0), 3'b100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5.inrst.%0d", k), obs(0), 3'b100);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("t5.post.%0d", k), obs(0), 3'b100);
    end
    data = 8'hC3; start_v[0] = 1'b1; push_frame(8'hC3, 0);
    drain(0, "t5new", exp_q.size(), 1, 0, 8'h00, 1'b0);

    // Long idle
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      chk($sformatf("t6.c%0d", k), obs(0), 3'b100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
